// File: rtl/mult_seq_32bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// iteration sizing.
package mult_seq_32bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MULT_ITER = 32;
  localparam int CNT_W     = 5;

endpackage : mult_seq_32bit_pkg

// File: rtl/mult_seq_32bit_add_stage.sv
// Combinational partial-sum adder: hi + (sel ? mcand : 0), with carry out.
// Kept separate so a faster adder can replace it without touching the FSM.
module mult_add_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic             sel,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  logic [WIDTH-1:0] addend;

  always_comb begin
    addend = sel ? mcand : '0;
    {c, s} = {1'b0, hi} + {1'b0, addend};
  end

endmodule : mult_add_stage

// File: rtl/mult_seq_32bit.sv
// Sequential unsigned 32x32 shift-add multiplier with start/done handshake.
// Fixed 32-iteration run; the product is held in hi/lo until the next start.
module mult_seq_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  import mult_seq_32bit_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_ITER - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_s;
  logic             add_c;

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .hi    (hi_q),
    .mcand (mcand_q),
    .sel   (lo_q[0]),
    .s     (add_s),
    .c     (add_c)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first; otherwise any path
    // that skips an assignment infers a latch.
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The carry becomes the new MSB of hi; dropping it corrupts large products.
        hi_d  = {add_c, add_s[WIDTH-1:1]};
        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop. All datapath flops are reset so the
  // product outputs read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign product_hi = hi_q;
  assign product_lo = lo_q;

endmodule : mult_seq_32bit
